// File: rtl/audio_stream_pkg.sv
// Shared definitions for the UART-to-DAC stereo sample path.
// - state_t      : byte-position states of the frame assembler (WAIT0..WAIT3)
// - *_LSB        : bit position of each byte lane inside a 32-bit stereo frame
//                  (left in [31:16], right in [15:0], each 16-bit little-endian)
// - FRAME_BITS   : width of one stereo sample word
package audio_stream_pkg;

  localparam int FRAME_BITS = 32;

  typedef enum logic [1:0] {
    WAIT0 = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2,
    WAIT3 = 2'd3
  } state_t;

  // Byte lane positions, in the order the host sends them.
  localparam int L_LO_LSB = 16;  // [23:16]
  localparam int L_HI_LSB = 24;  // [31:24]
  localparam int R_LO_LSB = 0;   // [7:0]
  localparam int R_HI_LSB = 8;   // [15:8]

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap timer.
// Counts clock cycles while 'run' is high; 'clear' returns the count to zero
// and has priority. 'expired' is high while running with the count at
// CYCLES-1, i.e. in the cycle where the gap limit is reached.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear of the count
//   run          : enable counting
//   expired      : gap limit reached this cycle
module byte_gap_timer #(
  parameter int CYCLES = 1200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/stereo_frame_assembler.sv
// Collects UART bytes into 32-bit stereo frames and writes them to the FIFO.
// A partial frame is abandoned after TIMEOUT_US of line silence (frame_error
// pulse) or on sync_clear; frames completing while the FIFO is full are
// dropped and counted in a saturating counter.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   rx_data/rx_received: byte and its single-cycle strobe from uart_rx
//   sync_clear         : level-sensitive realign request
//   fifo_full          : FIFO full flag, sampled with the 4th byte
//   fifo_wr_en/_data   : single-cycle write strobe and assembled frame
//   frame_error        : pulse when a partial frame times out
//   dropped            : saturating count of frames dropped on fifo_full
//   busy               : a partial frame is being held
module stereo_frame_assembler
  import audio_stream_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int TIMEOUT_US = 100,
  parameter int DROP_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_received,
  input  logic                  sync_clear,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [FRAME_BITS-1:0] fifo_wr_data,
  output logic                  frame_error,
  output logic [DROP_BITS-1:0]  dropped,
  output logic                  busy
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;

  state_t state;
  logic   expired;
  logic   timer_clear;

  // A timeout returns to WAIT0, so it clears the counter like a byte does.
  assign timer_clear = sync_clear | rx_received | expired;

  byte_gap_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .run    (state != WAIT0),
    .expired(expired)
  );

  // fifo_wr_data doubles as the assembly register: each byte is written
  // straight into its lane, and stale lanes from an aborted frame are always
  // overwritten before the next write strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_error  <= 1'b0;
      dropped      <= '0;
      busy         <= 1'b0;
    end else begin
      fifo_wr_en  <= 1'b0;
      frame_error <= 1'b0;
      if (sync_clear) begin
        state <= WAIT0;
        busy  <= 1'b0;
      end else if (rx_received) begin
        case (state)
          WAIT0: begin
            fifo_wr_data[L_LO_LSB +: 8] <= rx_data;
            state <= WAIT1;
            busy  <= 1'b1;
          end
          WAIT1: begin
            fifo_wr_data[L_HI_LSB +: 8] <= rx_data;
            state <= WAIT2;
            busy  <= 1'b1;
          end
          WAIT2: begin
            fifo_wr_data[R_LO_LSB +: 8] <= rx_data;
            state <= WAIT3;
            busy  <= 1'b1;
          end
          WAIT3: begin
            if (!fifo_full) begin
              fifo_wr_data[R_HI_LSB +: 8] <= rx_data;
              fifo_wr_en <= 1'b1;
            end else if (dropped != '1) begin
              dropped <= dropped + DROP_BITS'(1);
            end
            state <= WAIT0;
            busy  <= 1'b0;
          end
          default: begin
            state <= WAIT0;
            busy  <= 1'b0;
          end
        endcase
      end else if (expired) begin
        state       <= WAIT0;
        busy        <= 1'b0;
        frame_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stereo_frame_assembler.sv
module tb_stereo_frame_assembler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_received;
  logic        sync_clear;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        frame_error;
  logic [15:0] dropped;
  logic        busy;

  // Second instance with a 2-bit drop counter, driven by the same stimulus.
  logic        s_wr_en;
  logic [31:0] s_wr_data;
  logic        s_frame_error;
  logic [1:0]  s_dropped;
  logic        s_busy;

  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          err_cnt = 0;

  always #5 clk = ~clk;

  stereo_frame_assembler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_received (rx_received),
    .sync_clear  (sync_clear),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .frame_error (frame_error),
    .dropped     (dropped),
    .busy        (busy)
  );

  stereo_frame_assembler #(.DROP_BITS(2)) dut_sat (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_received (rx_received),
    .sync_clear  (sync_clear),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (s_wr_en),
    .fifo_wr_data(s_wr_data),
    .frame_error (s_frame_error),
    .dropped     (s_dropped),
    .busy        (s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe pops one expected frame.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (fifo_wr_en === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", {31'd0, fifo_wr_en}, 32'd0);
        else check("wr_data", fifo_wr_data, exp_q.pop_front());
      end
      if (frame_error === 1'b1) err_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic full);
    @(negedge clk);
    rx_data     = b;
    fifo_full   = full;
    rx_received = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
    fifo_full   = 1'b0;
  endtask

  // Sends a frame in wire order; pushes the expected word with the 4th byte.
  task automatic send_frame(input logic [31:0] w, input logic full, input int gap);
    logic [7:0] bytes [4];
    bytes[0] = w[23:16];
    bytes[1] = w[31:24];
    bytes[2] = w[7:0];
    bytes[3] = w[15:8];
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && !full) exp_q.push_back(w);
      send_byte(bytes[i], full);
      if (i < 3) repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    int wr_before;
    reset_n     = 1'b0;
    rx_data     = '0;
    rx_received = 1'b0;
    sync_clear  = 1'b0;
    fifo_full   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    check("rst_wr_data", fifo_wr_data, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("rst_dropped", {16'd0, dropped}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Spaced bytes forming 0x12345678.
    send_byte(8'h34, 1'b0);
    check("t1_busy_rise", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    send_byte(8'h12, 1'b0);
    repeat (9) @(negedge clk);
    send_byte(8'h78, 1'b0);
    repeat (9) @(negedge clk);
    check("t1_no_early_write", {31'd0, fifo_wr_en}, 32'd0);
    exp_q.push_back(32'h12345678);
    send_byte(8'h56, 1'b0);
    check("t1_wr_en", {31'd0, fifo_wr_en}, 32'd1);
    check("t1_busy_fall", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t1_wr_en_single", {31'd0, fifo_wr_en}, 32'd0);
    repeat (3) @(negedge clk);

    // Eight back-to-back bytes.
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5) check("b2b_wr1_en", {31'd0, fifo_wr_en}, 32'd1);
      if (i == 6) check("b2b_wr1_single", {31'd0, fifo_wr_en}, 32'd0);
      rx_data     = 8'(i);
      rx_received = 1'b1;
      if (i == 4) exp_q.push_back(32'h02010403);
      if (i == 8) exp_q.push_back(32'h06050807);
    end
    @(negedge clk);
    rx_received = 1'b0;
    check("b2b_wr2_en", {31'd0, fifo_wr_en}, 32'd1);
    repeat (3) @(negedge clk);
    check("b2b_writes", 32'(wr_cnt), 32'd3);

    // Timeout after two bytes.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (1199) @(negedge clk);
    check("to_not_yet", {31'd0, frame_error}, 32'd0);
    check("to_busy_held", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("to_frame_error", {31'd0, frame_error}, 32'd1);
    check("to_busy_fall", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("to_error_single", {31'd0, frame_error}, 32'd0);
    send_frame(32'hAABBCCDD, 1'b0, 1);
    @(negedge clk);
    check("to_err_count", 32'(err_cnt), 32'd1);
    check("to_writes", 32'(wr_cnt), 32'd4);

    // Third byte lands exactly on the expiry cycle.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (1198) @(negedge clk);
    send_byte(8'h33, 1'b0);
    check("edge_no_error", {31'd0, frame_error}, 32'd0);
    check("edge_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(32'h22114433);
    send_byte(8'h44, 1'b0);
    check("edge_wr_en", {31'd0, fifo_wr_en}, 32'd1);
    repeat (2) @(negedge clk);
    check("edge_err_count", 32'(err_cnt), 32'd1);

    // Drops while the FIFO is full, including saturation of the narrow counter.
    wr_before = wr_cnt;
    for (int f = 0; f < 3; f++) send_frame(32'hA0A1A2A3 + 32'(f), 1'b1, 2);
    @(negedge clk);
    check("drop_count3", {16'd0, dropped}, 32'd3);
    check("drop_sat_count3", {30'd0, s_dropped}, 32'd3);
    check("drop_no_writes", 32'(wr_cnt), 32'(wr_before));
    for (int f = 0; f < 2; f++) send_frame(32'hB0B1B2B3 + 32'(f), 1'b1, 0);
    @(negedge clk);
    check("drop_count5", {16'd0, dropped}, 32'd5);
    check("drop_sat_hold", {30'd0, s_dropped}, 32'd3);
    send_frame(32'h0BADF00D, 1'b0, 1);
    check("drop_release_wr", {31'd0, fifo_wr_en}, 32'd1);
    repeat (2) @(negedge clk);

    // sync_clear coincident with a 4th byte.
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    @(negedge clk);
    rx_data     = 8'h04;
    rx_received = 1'b1;
    sync_clear  = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
    sync_clear  = 1'b0;
    check("sync_no_write", {31'd0, fifo_wr_en}, 32'd0);
    check("sync_busy", {31'd0, busy}, 32'd0);
    check("sync_dropped_kept", {16'd0, dropped}, 32'd5);
    @(negedge clk);
    check("sync_no_error", {31'd0, frame_error}, 32'd0);
    send_frame(32'hCAFEBABE, 1'b0, 0);
    check("sync_realigned_wr", {31'd0, fifo_wr_en}, 32'd1);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-frame.
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_wr_data", fifo_wr_data, 32'd0);
    check("arst_dropped", {16'd0, dropped}, 32'd0);
    check("arst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(32'h13579BDF, 1'b0, 1);
    check("post_rst_wr", {31'd0, fifo_wr_en}, 32'd1);
    repeat (3) @(negedge clk);

    check("final_writes", 32'(wr_cnt), 32'd8);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_errors", 32'(err_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
